// File: rtl/syncgen_shadow_if.sv
// Configuration bus between the register block and syncgen_shadow:
// modeline fields, load strobe, and the apply/reject status returned by the generator.
interface syncgen_shadow_if #(
  parameter int CNT_WIDTH = 12,
  parameter int REP_WIDTH = 2
);
  logic                 cfg_load;
  logic [CNT_WIDTH-1:0] cfg_h_res;
  logic [CNT_WIDTH-1:0] cfg_h_sync_start;
  logic [CNT_WIDTH-1:0] cfg_h_sync_end;
  logic [CNT_WIDTH-1:0] cfg_h_length;
  logic [CNT_WIDTH-1:0] cfg_h_halfline;
  logic [CNT_WIDTH-1:0] cfg_v_res;
  logic [CNT_WIDTH-1:0] cfg_v_sync_start;
  logic [CNT_WIDTH-1:0] cfg_v_sync_end;
  logic [CNT_WIDTH-1:0] cfg_v_length;
  logic                 cfg_interlaced;
  logic [REP_WIDTH-1:0] cfg_h_rep;
  logic                 cfg_pending;
  logic                 cfg_ack;
  logic                 cfg_err;

  modport master (
    output cfg_load, cfg_h_res, cfg_h_sync_start, cfg_h_sync_end, cfg_h_length,
           cfg_h_halfline, cfg_v_res, cfg_v_sync_start, cfg_v_sync_end, cfg_v_length,
           cfg_interlaced, cfg_h_rep,
    input  cfg_pending, cfg_ack, cfg_err
  );

  modport slave (
    input  cfg_load, cfg_h_res, cfg_h_sync_start, cfg_h_sync_end, cfg_h_length,
           cfg_h_halfline, cfg_v_res, cfg_v_sync_start, cfg_v_sync_end, cfg_v_length,
           cfg_interlaced, cfg_h_rep,
    output cfg_pending, cfg_ack, cfg_err
  );
endinterface

// File: rtl/syncgen_shadow.sv
// Video timing generator with shadowed modeline registers applied only at the frame
// boundary; supports horizontal pixel repetition and interlaced fields.
module syncgen_shadow #(
  parameter int CNT_WIDTH = 12,
  parameter int REP_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  syncgen_shadow_if.slave      cfg,
  output logic [CNT_WIDTH-1:0] h_pos,
  output logic [CNT_WIDTH-1:0] v_pos,
  output logic                 pixel_en,
  output logic                 h_sync,
  output logic                 v_sync,
  output logic                 c_sync,
  output logic                 h_blank,
  output logic                 v_blank,
  output logic                 field,
  output logic                 frame_start
);
  typedef logic [CNT_WIDTH-1:0] cnt_t;

  typedef struct packed {
    cnt_t                 h_res;
    cnt_t                 h_sync_start;
    cnt_t                 h_sync_end;
    cnt_t                 h_length;
    cnt_t                 h_halfline;
    cnt_t                 v_res;
    cnt_t                 v_sync_start;
    cnt_t                 v_sync_end;
    cnt_t                 v_length;
    logic                 interlaced;
    logic [REP_WIDTH-1:0] h_rep;
  } modeline_t;

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_q, state_d;
  modeline_t            cfg_in, staging_q, active_q, apply_src;
  logic                 pending_q, load_ok, do_apply;
  cnt_t                 dot_q, line_q, hcnt_q, v_edge;
  logic [REP_WIDTH-1:0] rep_q;
  logic                 field_q;
  logic                 last_dot, last_line, at_apply;
  logic                 hb_d, vb_d, hs_d, vs_d, vs_after, vs_before;

  assign cfg_in = '{h_res:        cfg.cfg_h_res,
                    h_sync_start: cfg.cfg_h_sync_start,
                    h_sync_end:   cfg.cfg_h_sync_end,
                    h_length:     cfg.cfg_h_length,
                    h_halfline:   cfg.cfg_h_halfline,
                    v_res:        cfg.cfg_v_res,
                    v_sync_start: cfg.cfg_v_sync_start,
                    v_sync_end:   cfg.cfg_v_sync_end,
                    v_length:     cfg.cfg_v_length,
                    interlaced:   cfg.cfg_interlaced,
                    h_rep:        cfg.cfg_h_rep};

  assign load_ok = cfg.cfg_load
                && (cfg.cfg_h_length >= cnt_t'(2)) && (cfg.cfg_v_length >= cnt_t'(2))
                && (cfg.cfg_h_res <= cfg.cfg_h_length) && (cfg.cfg_v_res <= cfg.cfg_v_length);

  // A load accepted in the apply cycle bypasses staging and takes effect directly.
  assign apply_src = load_ok ? cfg_in : staging_q;

  assign last_dot  = dot_q  >= active_q.h_length - 1'b1;
  assign last_line = line_q >= active_q.v_length - 1'b1;
  assign at_apply  = last_dot && last_line && (field_q || !active_q.interlaced);

  // Field 1 moves both v_sync edges from dot 0 to the half-line dot.
  assign v_edge    = field_q ? active_q.h_halfline : '0;
  assign vs_after  = (line_q > active_q.v_sync_start)
                  || ((line_q == active_q.v_sync_start) && (dot_q >= v_edge));
  assign vs_before = (line_q < active_q.v_sync_end)
                  || ((line_q == active_q.v_sync_end) && (dot_q < v_edge));
  assign vs_d      = vs_after && vs_before;
  assign hs_d      = (dot_q >= active_q.h_sync_start) && (dot_q < active_q.h_sync_end);
  assign hb_d      = dot_q  >= active_q.h_res;
  assign vb_d      = line_q >= active_q.v_res;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d  = state_q;
    do_apply = 1'b0;
    case (state_q)
      IDLE: begin
        if (clk_en && pending_q) begin
          do_apply = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (clk_en && at_apply && (pending_q || load_ok)) do_apply = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q         <= IDLE;
      pending_q       <= 1'b0;
      staging_q       <= '0;
      active_q        <= '0;
      cfg.cfg_ack     <= 1'b0;
      cfg.cfg_err     <= 1'b0;
    end else begin
      state_q         <= state_d;
      cfg.cfg_ack     <= do_apply;
      cfg.cfg_err     <= cfg.cfg_load && !load_ok;
      if (load_ok) staging_q <= cfg_in;
      if (do_apply) begin
        active_q  <= apply_src;
        pending_q <= 1'b0;
      end else if (load_ok) begin
        pending_q <= 1'b1;
      end
    end
  end

  assign cfg.cfg_pending = pending_q;

  always_ff @(posedge clk) begin
    if (rst || state_q == IDLE) begin
      dot_q       <= '0;
      line_q      <= '0;
      hcnt_q      <= '0;
      rep_q       <= '0;
      field_q     <= 1'b0;
      h_pos       <= '0;
      v_pos       <= '0;
      pixel_en    <= 1'b0;
      h_sync      <= 1'b0;
      v_sync      <= 1'b0;
      c_sync      <= 1'b0;
      h_blank     <= 1'b1;
      v_blank     <= 1'b1;
      field       <= 1'b0;
      frame_start <= 1'b0;
    end else if (clk_en) begin
      h_pos       <= hcnt_q;
      v_pos       <= active_q.interlaced ? {line_q[CNT_WIDTH-2:0], field_q} : line_q;
      pixel_en    <= !hb_d && !vb_d && (rep_q == '0);
      h_sync      <= hs_d;
      v_sync      <= vs_d;
      c_sync      <= hs_d ^ vs_d;
      h_blank     <= hb_d;
      v_blank     <= vb_d;
      field       <= field_q;
      frame_start <= (dot_q == '0) && (line_q == '0) && !field_q;

      if (last_dot) begin
        dot_q  <= '0;
        rep_q  <= '0;
        hcnt_q <= '0;
        if (last_line) begin
          line_q  <= '0;
          field_q <= active_q.interlaced ? !field_q : 1'b0;
        end else begin
          line_q <= line_q + 1'b1;
        end
      end else begin
        dot_q <= dot_q + 1'b1;
        if (rep_q == active_q.h_rep) begin
          rep_q  <= '0;
          hcnt_q <= hcnt_q + 1'b1;
        end else begin
          rep_q <= rep_q + 1'b1;
        end
      end

      if (do_apply) begin
        dot_q   <= '0;
        line_q  <= '0;
        hcnt_q  <= '0;
        rep_q   <= '0;
        field_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_syncgen_shadow.sv
// Scoreboard bench for syncgen_shadow: a behavioural model predicts every registered
// output per clock; predictions are queued at drive time and compared after the edge.
module tb_syncgen_shadow;
  logic        clk, rst, clk_en;
  logic [11:0] h_pos, v_pos;
  logic        pixel_en, h_sync, v_sync, c_sync, h_blank, v_blank, field, frame_start;

  syncgen_shadow_if #(.CNT_WIDTH(12), .REP_WIDTH(2)) bus ();

  syncgen_shadow #(.CNT_WIDTH(12), .REP_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .cfg(bus),
    .h_pos(h_pos), .v_pos(v_pos), .pixel_en(pixel_en), .h_sync(h_sync),
    .v_sync(v_sync), .c_sync(c_sync), .h_blank(h_blank), .v_blank(v_blank),
    .field(field), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [34:0] obs;
  assign obs = {bus.cfg_pending, bus.cfg_ack, bus.cfg_err, h_pos, v_pos, pixel_en,
                h_sync, v_sync, c_sync, h_blank, v_blank, field, frame_start};

  typedef struct {
    int hr, hss, hse, hl, hh, vr, vss, vse, vl, rep;
    bit il;
  } ml_t;

  ml_t drv, m_stg, m_act;
  bit  m_run, m_pend, m_ack, m_err;
  int  m_dot, m_line, m_field;
  logic [31:0] m_out;
  logic [34:0] sb[$];

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int en_idx = 0, last_fs = -1, fs_period = 0, pe_cnt = 0, pe_frame = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic ml_t mk(int hr, int hss, int hse, int hl, int hh, int vr, int vss,
                             int vse, int vl, bit il, int rep);
    ml_t m;
    m.hr = hr; m.hss = hss; m.hse = hse; m.hl = hl; m.hh = hh;
    m.vr = vr; m.vss = vss; m.vse = vse; m.vl = vl; m.il = il; m.rep = rep;
    return m;
  endfunction

  task automatic set_cfg();
    bus.cfg_h_res        = 12'(drv.hr);
    bus.cfg_h_sync_start = 12'(drv.hss);
    bus.cfg_h_sync_end   = 12'(drv.hse);
    bus.cfg_h_length     = 12'(drv.hl);
    bus.cfg_h_halfline   = 12'(drv.hh);
    bus.cfg_v_res        = 12'(drv.vr);
    bus.cfg_v_sync_start = 12'(drv.vss);
    bus.cfg_v_sync_end   = 12'(drv.vse);
    bus.cfg_v_length     = 12'(drv.vl);
    bus.cfg_interlaced   = drv.il;
    bus.cfg_h_rep        = 2'(drv.rep);
  endtask

  // Outputs for the dot the model currently sits on, derived from position arithmetic.
  function automatic logic [31:0] dot_out();
    int  hp, vp, pos, sp, ep, ed;
    bit  pe, hs, vs, hb, vb, fs;
    hb  = m_dot >= m_act.hr;
    vb  = m_line >= m_act.vr;
    hp  = m_dot / (m_act.rep + 1);
    pe  = !hb && !vb && ((m_dot % (m_act.rep + 1)) == 0);
    hs  = (m_dot >= m_act.hss) && (m_dot < m_act.hse);
    ed  = (m_field == 1) ? m_act.hh : 0;
    pos = m_line * m_act.hl + m_dot;
    sp  = m_act.vss * m_act.hl + ed;
    ep  = m_act.vse * m_act.hl + ed;
    vs  = (pos >= sp) && (pos < ep);
    vp  = m_act.il ? (2 * m_line + m_field) : m_line;
    fs  = (m_dot == 0) && (m_line == 0) && (m_field == 0);
    return {12'(hp), 12'(vp), pe, hs, vs, hs ^ vs, hb, vb, bit'(m_field), fs};
  endfunction

  function automatic bit model_at_apply();
    return m_run && (m_dot == m_act.hl - 1) && (m_line == m_act.vl - 1)
        && ((m_field == 1) || !m_act.il);
  endfunction

  task automatic model_edge(input bit r, input bit en, input bit load);
    bit ok, apply, at_end;
    if (r) begin
      m_run = 0; m_pend = 0; m_ack = 0; m_err = 0;
      m_dot = 0; m_line = 0; m_field = 0;
      m_out = 32'h0000_000C;
      return;
    end
    ok = load && (drv.hl >= 2) && (drv.vl >= 2) && (drv.hr <= drv.hl) && (drv.vr <= drv.vl);
    m_err = load && !ok;
    apply = 0;
    if (!m_run) begin
      if (en && m_pend) begin
        apply = 1;
        m_run = 1;
      end
    end else if (en) begin
      at_end = model_at_apply();
      m_out = dot_out();
      m_dot++;
      if (m_dot == m_act.hl) begin
        m_dot = 0;
        m_line++;
        if (m_line == m_act.vl) begin
          m_line  = 0;
          m_field = m_act.il ? 1 - m_field : 0;
        end
      end
      if (at_end && (m_pend || ok)) apply = 1;
    end
    m_ack = apply;
    if (apply) begin
      m_act  = ok ? drv : m_stg;
      m_pend = 0;
      m_dot = 0; m_line = 0; m_field = 0;
    end else if (ok) begin
      m_stg  = drv;
      m_pend = 1;
    end
  endtask

  task automatic step(input bit en, input bit load, input bit do_rst);
    logic [34:0] want;
    @(negedge clk);
    rst = do_rst;
    clk_en = en;
    bus.cfg_load = load;
    set_cfg();
    model_edge(do_rst, en, load);
    sb.push_back({m_pend, m_ack, m_err, m_out});
    @(posedge clk);
    #1;
    want = sb.pop_front();
    check($sformatf("cycle%0d", cyc), 64'(obs), 64'(want));
    cyc++;
    if (en && !do_rst) begin
      if (frame_start) begin
        if (last_fs >= 0) begin
          fs_period = en_idx - last_fs;
          pe_frame  = pe_cnt;
        end
        last_fs = en_idx;
        pe_cnt  = 0;
      end
      if (pixel_en) pe_cnt++;
      en_idx++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic run_to_apply(input string tag);
    bit found = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      if (model_at_apply()) found = 1;
      else step(1'b1, 1'b0, 1'b0);
    end
    if (!found) check(tag, 64'(0), 64'(1));
  endtask

  ml_t cfg_a, cfg_b, cfg_c, cfg_d;

  initial begin
    rst = 1'b1; clk_en = 1'b0; bus.cfg_load = 1'b0;
    cfg_a = mk(8, 10, 12, 16, 0, 4, 5, 6, 8, 1'b0, 0);
    cfg_b = mk(12, 13, 14, 16, 0, 4, 5, 6, 8, 1'b0, 2);
    cfg_c = mk(12, 13, 14, 20, 0, 4, 5, 6, 8, 1'b0, 2);
    cfg_d = mk(8, 10, 12, 16, 8, 4, 5, 6, 8, 1'b1, 0);
    drv = cfg_a;
    set_cfg();

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
    run(3);

    // Progressive 16x8 frame, no repetition.
    step(1'b1, 1'b1, 1'b0);
    run(300);
    check("a_frame_period", 64'(fs_period), 64'(128));
    check("a_pixels_per_frame", 64'(pe_frame), 64'(32));

    // Triple repetition over 12 visible dots.
    drv = cfg_b;
    step(1'b1, 1'b1, 1'b0);
    run(400);
    check("b_frame_period", 64'(fs_period), 64'(128));
    check("b_pixels_per_frame", 64'(pe_frame), 64'(16));

    // Rejected loads leave staging and pending alone.
    drv = cfg_b; drv.hl = 1;
    step(1'b1, 1'b1, 1'b0);
    drv = cfg_b; drv.hr = 17;
    step(1'b1, 1'b1, 1'b0);
    run(4);
    check("err_pending", 64'(bus.cfg_pending), 64'(0));

    // Mid-frame load of a longer line; takes effect only at the frame boundary.
    for (int i = 0; i < 200 && m_line != 3; i++) step(1'b1, 1'b0, 1'b0);
    drv = cfg_c;
    step(1'b1, 1'b1, 1'b0);
    check("c_pending_set", 64'(bus.cfg_pending), 64'(1));
    run(500);
    check("c_frame_period", 64'(fs_period), 64'(160));

    // Interlaced: frame_start only in field 0, two fields per frame.
    drv = cfg_d;
    step(1'b1, 1'b1, 1'b0);
    run(900);
    check("d_frame_period", 64'(fs_period), 64'(256));
    check("d_pixels_per_frame", 64'(pe_frame), 64'(64));

    // Load exactly on the apply dot: applied immediately, nothing left pending.
    run_to_apply("apply_wait");
    drv = cfg_a;
    step(1'b1, 1'b1, 1'b0);
    check("bypass_ack", 64'(bus.cfg_ack), 64'(1));
    check("bypass_pending", 64'(bus.cfg_pending), 64'(0));
    run(200);

    // Stalled dot enable must not change the per-enabled-cycle sequence.
    for (int i = 0; i < 300; i++) step(bit'(i % 2 == 0), 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) step(bit'($urandom_range(0, 1)), 1'b0, 1'b0);
    run(130);
    check("stall_frame_period", 64'(fs_period), 64'(128));

    // Reset mid-line discards a staged modeline.
    drv = cfg_b;
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 40 && m_dot != 5; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check("rst_h_blank", 64'(h_blank), 64'(1));
    run(6);
    check("rst_no_apply", 64'(bus.cfg_pending), 64'(0));
    drv = cfg_a;
    step(1'b1, 1'b1, 1'b0);
    run(20);

    if (sb.size() != 0) check("scoreboard_drain", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
